// File: rtl/generador_pasos_pkg.sv
// Shared types and helpers for the step-pulse generator.
// POS_W is the width of every position value handled by the block.
package generador_pasos_pkg;

    localparam int POS_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        PULSE,
        WAIT
    } estado_t;

    function automatic logic [POS_W-1:0] limitar(
        input logic [POS_W-1:0] valor,
        input logic [POS_W-1:0] minimo,
        input logic [POS_W-1:0] maximo
    );
        if (valor < minimo) begin
            return minimo;
        end
        if (valor > maximo) begin
            return maximo;
        end
        return valor;
    endfunction

endpackage

// File: rtl/divisor_intervalo.sv
// Loadable down-counter that times the WAIT interval between step pulses.
// It stops at zero and holds there until the next load.
module divisor_intervalo #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= value;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - W'(1);
        end
    end

    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/generador_pasos.sv
// Step-pulse generator: walks an external up/down position counter toward a target.
// Defining GENERADOR_PASOS_SOFT_LIMIT_EN clamps accepted targets to [POS_MIN, POS_MAX].
module generador_pasos
    import generador_pasos_pkg::*;
#(
    parameter int STEP_DIV = 50000,
    parameter int POS_MIN  = 10,
    parameter int POS_MAX  = 170
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [POS_W-1:0] tgt_pos,
    input  logic [POS_W-1:0] pos,
    input  logic             abort,
    output logic             cnt_up,
    output logic             cnt_down,
    output logic             busy,
    output logic             done
);

    // WAIT spans STEP_DIV-2 cycles; the counter runs from STEP_DIV-3 down to 0.
    localparam int CNT_W = $clog2(STEP_DIV);
    localparam logic [CNT_W-1:0] CUENTA_WAIT = CNT_W'(STEP_DIV - 3);

`ifdef GENERADOR_PASOS_SOFT_LIMIT_EN
    localparam bit LIMITE_EN = 1'b1;
`else
    localparam bit LIMITE_EN = 1'b0;
`endif

    estado_t          estado_reg;
    logic [POS_W-1:0] tgt_q;
    logic [POS_W-1:0] tgt_in;
    logic             dir_reg;
    logic             dir_next;
    logic             entra_pulso;
    logic             carga_intervalo;
    logic             intervalo_cero;

    assign tgt_in = LIMITE_EN ? limitar(tgt_pos, POS_W'(POS_MIN), POS_W'(POS_MAX)) : tgt_pos;

    assign tgt_ready = (estado_reg == IDLE) && !abort;

    // A step is issued only when CHECK finds distance left and no cancel is pending.
    assign entra_pulso = (estado_reg == CHECK) && !abort && (pos != tgt_q);

    always_comb begin
        dir_next = dir_reg;
        if (entra_pulso) begin
            dir_next = (pos < tgt_q);
        end
    end

    assign carga_intervalo = (estado_reg == PULSE);

    divisor_intervalo #(
        .W (CNT_W)
    ) u_divisor (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (carga_intervalo),
        .value (CUENTA_WAIT),
        .zero  (intervalo_cero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg <= IDLE;
            tgt_q      <= '0;
            dir_reg    <= 1'b0;
            cnt_up     <= 1'b0;
            cnt_down   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            dir_reg  <= dir_next;
            cnt_up   <= entra_pulso && dir_next;
            cnt_down <= entra_pulso && !dir_next;
            done     <= 1'b0;
            case (estado_reg)
                IDLE: begin
                    if (tgt_valid && tgt_ready) begin
                        tgt_q      <= tgt_in;
                        estado_reg <= CHECK;
                        busy       <= 1'b1;
                    end
                end
                CHECK: begin
                    if (abort) begin
                        estado_reg <= IDLE;
                        busy       <= 1'b0;
                    end else if (pos == tgt_q) begin
                        estado_reg <= IDLE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        estado_reg <= PULSE;
                    end
                end
                PULSE: begin
                    if (abort) begin
                        estado_reg <= IDLE;
                        busy       <= 1'b0;
                    end else begin
                        estado_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (abort) begin
                        estado_reg <= IDLE;
                        busy       <= 1'b0;
                    end else if (intervalo_cero) begin
                        estado_reg <= CHECK;
                    end
                end
                default: begin
                    estado_reg <= IDLE;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_generador_pasos.sv
// Randomized bench for generador_pasos (STEP_DIV=4) with a schedule-based reference model.
// Honours GENERADOR_PASOS_SOFT_LIMIT_EN the same way the design does.
module tb_generador_pasos;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tgt_valid;
    logic       tgt_ready;
    logic [7:0] tgt_pos;
    logic [7:0] pos;
    logic       abort;
    logic       cnt_up;
    logic       cnt_down;
    logic       busy;
    logic       done;

    int         total = 0;
    int         aciertos = 0;
    logic [7:0] pos_m;

    generador_pasos #(
        .STEP_DIV (S),
        .POS_MIN  (10),
        .POS_MAX  (170)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tgt_valid (tgt_valid),
        .tgt_ready (tgt_ready),
        .tgt_pos   (tgt_pos),
        .pos       (pos),
        .abort     (abort),
        .cnt_up    (cnt_up),
        .cnt_down  (cnt_down),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Environment: the up/down position counter the block steers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos <= 8'd45;
        end else if (cnt_up) begin
            pos <= pos + 8'd1;
        end else if (cnt_down) begin
            pos <= pos - 8'd1;
        end
    end

    task automatic comprobar(input string tag, input int obs, input int esp);
        total++;
        if (obs == esp) begin
            aciertos++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    function automatic logic [7:0] objetivo_efectivo(input logic [7:0] t);
`ifdef GENERADOR_PASOS_SOFT_LIMIT_EN
        if (t < 8'd10) return 8'd10;
        if (t > 8'd170) return 8'd170;
`endif
        return t;
    endfunction

    // One move: handshake, then per-cycle comparison against the step schedule.
    // rel counts cycles after the handshake edge; pulse k is visible at rel=1+k*S,
    // done at rel=1+n*S. Abort raised at sample rel=a takes effect at the next edge.
    task automatic mover(input logic [7:0] t, input int a);
        logic [7:0] tq;
        bit         up;
        int         n;
        int         pulsos;
        bit         aborted;
        bit         ep;
        bit         eb;
        bit         ed;
        tq     = objetivo_efectivo(t);
        up     = (pos_m < tq);
        n      = up ? int'(tq) - int'(pos_m) : int'(pos_m) - int'(tq);
        pulsos = 0;
        tgt_pos   = t;
        tgt_valid = 1'b1;
        abort     = 1'b0;
        @(posedge clk);
        for (int rel = 0; rel <= n * S + 1; rel++) begin
            @(negedge clk);
            aborted = (a >= 0) && (rel > a);
            ep = !aborted && (n > 0) && (rel >= 1) && ((rel - 1) % S == 0) && ((rel - 1) / S < n);
            eb = !aborted && (rel <= n * S);
            ed = !aborted && (rel == n * S + 1);
            if (ep) pulsos++;
            comprobar("cnt_up", int'(cnt_up), int'(ep && up));
            comprobar("cnt_down", int'(cnt_down), int'(ep && !up));
            comprobar("busy", int'(busy), int'(eb));
            comprobar("done", int'(done), int'(ed));
            comprobar("tgt_ready", int'(tgt_ready), int'(!eb && !abort));
            if (aborted || !eb) break;
            abort     = (rel == a);
            tgt_valid = 1'($urandom_range(0, 1));
            tgt_pos   = 8'($urandom_range(0, 255));
            @(posedge clk);
        end
        abort     = 1'b0;
        tgt_valid = 1'b0;
        pos_m = up ? pos_m + 8'(pulsos) : pos_m - 8'(pulsos);
        comprobar("pos", int'(pos), int'(pos_m));
        $display("move target=%0d latched=%0d abort_at=%0d pulses=%0d pos=%0d", t, tq, a, pulsos, pos);
    endtask

    initial begin
        int t;
        int a;
        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_pos   = 8'd0;
        abort     = 1'b0;
        pos_m     = 8'd45;
        repeat (2) @(negedge clk);
        comprobar("rst_busy", int'(busy), 0);
        comprobar("rst_done", int'(done), 0);
        comprobar("rst_up", int'(cnt_up), 0);
        comprobar("rst_down", int'(cnt_down), 0);
        comprobar("rst_ready", int'(tgt_ready), 1);
        comprobar("rst_pos", int'(pos), 45);
        rst_n = 1'b1;
        @(negedge clk);

        mover(8'd45, -1);
        mover(8'd48, -1);
        mover(8'd45, -1);
        mover(8'd42, -1);
        mover(8'd50, 6);
        comprobar("abort_pos", int'(pos), 44);
        mover(8'd200, -1);
`ifdef GENERADOR_PASOS_SOFT_LIMIT_EN
        comprobar("pos_limite", int'(pos), 170);
`else
        comprobar("pos_limite", int'(pos), 200);
`endif

        for (int i = 0; i < 10; i++) begin
            t = int'(pos_m) + int'($urandom_range(0, 30)) - 15;
            if (t < 0) t = 0;
            if (t > 255) t = 255;
            a = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) : -1;
            mover(8'(t), a);
        end

        // abort together with tgt_valid in IDLE must not start a move
        abort     = 1'b1;
        tgt_valid = 1'b1;
        tgt_pos   = 8'd100;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            comprobar("abort_idle_ready", int'(tgt_ready), 0);
            comprobar("abort_idle_busy", int'(busy), 0);
        end
        abort     = 1'b0;
        tgt_valid = 1'b0;
        @(negedge clk);

        // reset in the middle of a move
        tgt_pos   = 8'(int'(pos_m) + 20);
        tgt_valid = 1'b1;
        @(posedge clk);
        tgt_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        comprobar("mid_rst_busy", int'(busy), 0);
        comprobar("mid_rst_up", int'(cnt_up | cnt_down), 0);
        comprobar("mid_rst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pos_m = 8'd45;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            comprobar("post_rst_pulse", int'(cnt_up | cnt_down), 0);
            comprobar("post_rst_busy", int'(busy), 0);
        end
        comprobar("post_rst_pos", int'(pos), 45);
        mover(8'd47, -1);

        $display("%0d/%0d checks passed", aciertos, total);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
